mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM state encoding, access size codes and small helper functions.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_INST  = 2'b01,
        ST_DATA  = 2'b10,
        ST_DRAIN = 2'b11
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Width of a counter that must hold values 0..limit (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

    // Zero-extend load data according to the access size.
    function automatic logic [31:0] zext_load(input logic [31:0] data,
                                              input logic [1:0]  sz);
        logic [31:0] res;
        case (sz)
            SZ_BYTE: res = {24'h000000, data[7:0]};
            SZ_HALF: res = {16'h0000, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and
// the byte-serial memory controller. The slave modport is the arbiter's view.
interface mem_arbiter_if;

    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_size;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic        mc_req;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic [1:0]  mc_size;
    logic        mc_done;
    logic [31:0] mc_rdata;

    logic        busy;

    modport slave (
        input  flush, if_req, if_addr,
        input  ls_req, ls_wr, ls_addr, ls_wdata, ls_size,
        input  mc_done, mc_rdata,
        output if_done, if_rdata, ls_done, ls_rdata,
        output mc_req, mc_wr, mc_addr, mc_wdata, mc_size,
        output busy
    );

    modport master (
        output flush, if_req, if_addr,
        output ls_req, ls_wr, ls_addr, ls_wdata, ls_size,
        output mc_done, mc_rdata,
        input  if_done, if_rdata, ls_done, ls_rdata,
        input  mc_req, mc_wr, mc_addr, mc_wdata, mc_size,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-serial memory controller between instruction
// fetch and load/store. Data has priority; a fetch in flight can be
// cancelled by flush (the access still drains), loads/stores never are.
// Optional macro STARVE_GUARD_EN adds a counter that forces a waiting
// fetch through after STARVE_LIMIT consecutive data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_e  state_q, state_d;
    logic        mc_req_q, mc_req_d;
    logic        mc_wr_q, mc_wr_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic [1:0]  mc_size_q, mc_size_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        slot_open;
    logic        fetch_ok;
    logic        data_ok;
    logic        starved;
    logic        grant_inst;
    logic        grant_data;

    // Arbitration: a done cycle is a dead slot for both requesters so a
    // requester holding its req is never re-granted in its own done cycle,
    // and a continuously held ls_req still keeps strict priority.
    always_comb begin
        slot_open  = (state_q == ST_IDLE) && !if_done_q && !ls_done_q;
        fetch_ok   = slot_open && bus.if_req && !bus.flush;
        data_ok    = slot_open && bus.ls_req;
        grant_inst = fetch_ok && (!data_ok || starved);
        grant_data = data_ok && !grant_inst;
    end

`ifdef STARVE_GUARD_EN
    localparam int unsigned      CNT_W   = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starved = (starve_cnt_q == CNT_MAX);

    // Count consecutive data grants while a fetch waits; saturate at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.if_req || grant_inst) begin
            starve_cnt_d = '0;
        end else if (grant_data && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d    = state_q;
        mc_req_d   = mc_req_q;
        mc_wr_d    = mc_wr_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        mc_size_d  = mc_size_q;
        if_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d    = ST_DATA;
                    mc_req_d   = 1'b1;
                    mc_wr_d    = bus.ls_wr;
                    mc_addr_d  = bus.ls_addr;
                    mc_wdata_d = bus.ls_wdata;
                    mc_size_d  = bus.ls_size;
                end else if (grant_inst) begin
                    state_d    = ST_INST;
                    mc_req_d   = 1'b1;
                    mc_wr_d    = 1'b0;
                    mc_addr_d  = bus.if_addr;
                    mc_wdata_d = '0;
                    mc_size_d  = SZ_WORD;
                end
            end
            ST_DATA: begin
                if (bus.mc_done) begin
                    state_d   = ST_IDLE;
                    mc_req_d  = 1'b0;
                    ls_done_d = 1'b1;
                    if (!mc_wr_q) begin
                        ls_rdata_d = zext_load(bus.mc_rdata, mc_size_q);
                    end
                end
            end
            ST_INST: begin
                if (bus.mc_done) begin
                    state_d  = ST_IDLE;
                    mc_req_d = 1'b0;
                    if (!bus.flush) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mc_rdata;
                    end
                end else if (bus.flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.mc_done) begin
                    state_d  = ST_IDLE;
                    mc_req_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mc_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mc_req_q   <= 1'b0;
            mc_wr_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
            mc_size_q  <= '0;
            if_done_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mc_req_q   <= mc_req_d;
            mc_wr_q    <= mc_wr_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            mc_size_q  <= mc_size_d;
            if_done_q  <= if_done_d;
            if_rdata_q <= if_rdata_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.mc_req   = mc_req_q;
    assign bus.mc_wr    = mc_wr_q;
    assign bus.mc_addr  = mc_addr_q;
    assign bus.mc_wdata = mc_wdata_q;
    assign bus.mc_size  = mc_size_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the
// falling clock edge; the memory controller is played by the bench.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test sequence");
        $fatal(1, "simulation timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mc_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.mc_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic mc_pulse(input logic [31:0] d);
        bus.mc_done  = 1'b1;
        bus.mc_rdata = d;
        @(negedge clk);
        bus.mc_done  = 1'b0;
        bus.mc_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        checks++; if (bus.mc_req !== 1'b0) begin errors++; $display("FAIL reset_mc_req: got %b want 0", bus.mc_req); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if ({bus.if_done, bus.ls_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {bus.if_done, bus.ls_done}); end
        checks++; if ({bus.mc_addr, bus.mc_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mc_bus: got %h want 0", {bus.mc_addr, bus.mc_wdata}); end
        checks++; if ({bus.if_rdata, bus.ls_rdata, bus.mc_wr, bus.mc_size} !== 67'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.ls_rdata, bus.mc_wr, bus.mc_size}); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_fetch();
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        cyc(1);
        checks++; if (bus.mc_req !== 1'b1) begin errors++; $display("FAIL fetch_mc_req: got %b want 1", bus.mc_req); end
        checks++; if (bus.mc_addr !== 32'h100) begin errors++; $display("FAIL fetch_mc_addr: got %h want 00000100", bus.mc_addr); end
        checks++; if ({bus.mc_wr, bus.mc_size} !== 3'b011) begin errors++; $display("FAIL fetch_wr_size: got %b want 011", {bus.mc_wr, bus.mc_size}); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fetch_busy: got %b want 1", bus.busy); end
        cyc(2);
        checks++; if ({bus.mc_req, bus.mc_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL fetch_hold: got %h want 100000100", {bus.mc_req, bus.mc_addr}); end
        checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done: got %b want 0", bus.if_done); end
        mc_pulse(32'h00A00093);
        checks++; if (bus.if_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b want 1", bus.if_done); end
        checks++; if (bus.if_rdata !== 32'h00A00093) begin errors++; $display("FAIL fetch_rdata: got %h want 00a00093", bus.if_rdata); end
        checks++; if ({bus.mc_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL fetch_release: got %b want 00", {bus.mc_req, bus.busy}); end
        bus.if_req = 1'b0;
        cyc(1);
        checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL fetch_done_width: got %b want 0", bus.if_done); end
    endtask

    task automatic test_back_to_back();
        bus.if_addr = 32'h180;
        bus.if_req  = 1'b1;
        cyc(1);
        mc_pulse(32'h11);
        bus.if_addr = 32'h184;
        cyc(1);
        checks++; if (bus.mc_req !== 1'b0) begin errors++; $display("FAIL b2b_no_regrant: got %b want 0", bus.mc_req); end
        cyc(1);
        checks++; if ({bus.mc_req, bus.mc_addr} !== {1'b1, 32'h184}) begin errors++; $display("FAIL b2b_regrant: got %h want 100000184", {bus.mc_req, bus.mc_addr}); end
        mc_pulse(32'h22);
        checks++; if ({bus.if_done, bus.if_rdata} !== {1'b1, 32'h22}) begin errors++; $display("FAIL b2b_done: got %h want 100000022", {bus.if_done, bus.if_rdata}); end
        bus.if_req = 1'b0;
        cyc(1);
    endtask

    task automatic test_priority();
        bus.if_addr  = 32'h200;
        bus.if_req   = 1'b1;
        bus.ls_addr  = 32'h1000;
        bus.ls_wr    = 1'b0;
        bus.ls_size  = 2'b11;
        bus.ls_req   = 1'b1;
        cyc(1);
        checks++; if ({bus.mc_req, bus.mc_wr, bus.mc_addr} !== {2'b10, 32'h1000}) begin errors++; $display("FAIL prio_data_first: got %h want 200001000", {bus.mc_req, bus.mc_wr, bus.mc_addr}); end
        cyc(1);
        mc_pulse(32'h11223344);
        checks++; if ({bus.ls_done, bus.if_done} !== 2'b10) begin errors++; $display("FAIL prio_ls_done: got %b want 10", {bus.ls_done, bus.if_done}); end
        checks++; if (bus.ls_rdata !== 32'h11223344) begin errors++; $display("FAIL prio_ls_rdata: got %h want 11223344", bus.ls_rdata); end
        bus.ls_req = 1'b0;
        cyc(2);
        checks++; if ({bus.mc_req, bus.mc_addr, bus.mc_size} !== {1'b1, 32'h200, 2'b11}) begin errors++; $display("FAIL prio_fetch_follows: got %h want %h", {bus.mc_req, bus.mc_addr, bus.mc_size}, {1'b1, 32'h200, 2'b11}); end
        cyc(1);
        mc_pulse(32'h00C00113);
        checks++; if ({bus.if_done, bus.ls_done, bus.if_rdata} !== {2'b10, 32'h00C00113}) begin errors++; $display("FAIL prio_if_done: got %h want 200c00113", {bus.if_done, bus.ls_done, bus.if_rdata}); end
        bus.if_req = 1'b0;
        cyc(1);
    endtask

    task automatic test_flush();
        bus.if_addr = 32'h300;
        bus.if_req  = 1'b1;
        bus.flush   = 1'b1;
        cyc(1);
        checks++; if ({bus.mc_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL flush_idle_ignore: got %b want 00", {bus.mc_req, bus.busy}); end
        bus.flush = 1'b0;
        cyc(1);
        checks++; if ({bus.mc_req, bus.mc_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL flush_grant: got %h want 100000300", {bus.mc_req, bus.mc_addr}); end
        bus.flush  = 1'b1;
        bus.if_req = 1'b0;
        cyc(1);
        bus.flush = 1'b0;
        checks++; if ({bus.mc_req, bus.busy} !== 2'b11) begin errors++; $display("FAIL flush_drain: got %b want 11", {bus.mc_req, bus.busy}); end
        cyc(1);
        mc_pulse(32'hDEADBEEF);
        checks++; if ({bus.if_done, bus.busy, bus.mc_req} !== 3'b000) begin errors++; $display("FAIL flush_discard: got %b want 000", {bus.if_done, bus.busy, bus.mc_req}); end
        checks++; if (bus.if_rdata !== 32'h00C00113) begin errors++; $display("FAIL flush_rdata_kept: got %h want 00c00113", bus.if_rdata); end
        cyc(1);
        checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL flush_late_done: got %b want 0", bus.if_done); end
        bus.if_addr = 32'h400;
        bus.if_req  = 1'b1;
        cyc(1);
        bus.flush  = 1'b1;
        bus.if_req = 1'b0;
        mc_pulse(32'h55555555);
        bus.flush = 1'b0;
        checks++; if ({bus.if_done, bus.busy} !== 2'b00) begin errors++; $display("FAIL flush_coincident: got %b want 00", {bus.if_done, bus.busy}); end
        cyc(1);
        checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL flush_coincident_late: got %b want 0", bus.if_done); end
    endtask

    task automatic test_store();
        bus.ls_addr  = 32'h2003;
        bus.ls_wdata = 32'h000000AB;
        bus.ls_size  = 2'b01;
        bus.ls_wr    = 1'b1;
        bus.ls_req   = 1'b1;
        cyc(1);
        checks++; if ({bus.mc_wr, bus.mc_size} !== 3'b101) begin errors++; $display("FAIL store_wr_size: got %b want 101", {bus.mc_wr, bus.mc_size}); end
        checks++; if ({bus.mc_addr, bus.mc_wdata} !== {32'h2003, 32'hAB}) begin errors++; $display("FAIL store_addr_data: got %h want 00002003000000ab", {bus.mc_addr, bus.mc_wdata}); end
        bus.flush = 1'b1;
        cyc(2);
        checks++; if ({bus.mc_req, bus.busy} !== 2'b11) begin errors++; $display("FAIL store_flush_ignored: got %b want 11", {bus.mc_req, bus.busy}); end
        mc_pulse(32'h0);
        checks++; if (bus.ls_done !== 1'b1) begin errors++; $display("FAIL store_done: got %b want 1", bus.ls_done); end
        bus.flush  = 1'b0;
        bus.ls_req = 1'b0;
        cyc(1);
        bus.ls_wr  = 1'b0;
        bus.ls_req = 1'b1;
        cyc(1);
        mc_pulse(32'h123456AB);
        checks++; if ({bus.ls_done, bus.ls_rdata} !== {1'b1, 32'hAB}) begin errors++; $display("FAIL load_byte_zext: got %h want 1000000ab", {bus.ls_done, bus.ls_rdata}); end
        bus.ls_req = 1'b0;
        cyc(1);
    endtask

    task automatic test_starve();
        bit          seen;
        logic [31:0] exp_addr;
        bus.if_addr = 32'h500;
        bus.if_req  = 1'b1;
        bus.ls_addr = 32'h3000;
        bus.ls_size = 2'b11;
        bus.ls_wr   = 1'b0;
        bus.ls_req  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_mc_req(seen);
            checks++; if (!seen) begin errors++; $display("FAIL starve_grant%0d: got no mc_req, want mc_req", k); end
            exp_addr = (GUARD && k == 5) ? 32'h500 : 32'h3000;
            checks++; if (bus.mc_addr !== exp_addr) begin errors++; $display("FAIL starve_addr%0d: got %h want %h", k, bus.mc_addr, exp_addr); end
            cyc(1);
            mc_pulse(32'(k));
        end
        bus.ls_req = 1'b0;
        if (!GUARD) begin
            wait_mc_req(seen);
            checks++; if (!seen || bus.mc_addr !== 32'h500) begin errors++; $display("FAIL starve_fetch_after: got %h want 00000500", bus.mc_addr); end
            cyc(1);
            mc_pulse(32'h66);
        end
        bus.if_req = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        bus.ls_addr = 32'h4000;
        bus.ls_size = 2'b11;
        bus.ls_wr   = 1'b0;
        bus.ls_req  = 1'b1;
        cyc(1);
        checks++; if ({bus.mc_req, bus.busy} !== 2'b11) begin errors++; $display("FAIL rstmid_started: got %b want 11", {bus.mc_req, bus.busy}); end
        rst = 1'b1;
        bus.ls_req = 1'b0;
        cyc(1);
        rst = 1'b0;
        checks++; if ({bus.mc_req, bus.busy, bus.ls_done, bus.if_done} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl: got %b want 0000", {bus.mc_req, bus.busy, bus.ls_done, bus.if_done}); end
        checks++; if ({bus.mc_addr, bus.ls_rdata, bus.if_rdata} !== 96'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", {bus.mc_addr, bus.ls_rdata, bus.if_rdata}); end
        saw_done = 1'b0;
        repeat (3) begin
            cyc(1);
            if (bus.ls_done !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got ls_done pulse, want none"); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_wr    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.ls_size  = '0;
        bus.mc_done  = 1'b0;
        bus.mc_rdata = '0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_priority();
        test_flush();
        test_store();
        test_starve();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
